enter_input_conditioner: RTL and testbench

Front-end stage between the board pins and the password game core. Synchronises the 10 raw switches and the raw `enter` button into the `clk` domain and debounces both. Emits exactly one single-cycle `guess_valid` strobe per physical press, with the debounced switch word captured alongside it. The strobe and captured word feed the user-input register and the password checker, replacing the raw `enter`/`sw` connection; a saturating guess counter is provided for the level display.

---
 rtl/enter_input_conditioner_pkg.sv | 15 +
 rtl/enter_input_conditioner_sync2.sv | 29 ++
 rtl/enter_input_conditioner.sv | 161 ++++++++++++++++
 tb/tb_enter_input_conditioner.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/enter_input_conditioner_pkg.sv
// Shared types and constants for the password game input front-end.
// Holds the enter-button FSM state type and the guess counter ceiling.
package perp_puzz_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } enter_state_t;

    localparam int         SW_WIDTH_DEF  = 10;
    localparam logic [3:0] GUESS_CNT_MAX = 4'd15;

endpackage

// File: rtl/enter_input_conditioner_sync2.sv
// Two-flop synchroniser for asynchronous board pins.
// One independent two-stage chain per bit, cleared by the asynchronous active-low reset.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                meta_q[gi] <= 1'b0;
                sync_q[gi] <= 1'b0;
            end else begin
                meta_q[gi] <= d[gi];
                sync_q[gi] <= meta_q[gi];
            end
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/enter_input_conditioner.sv
// Synchronises and debounces the switches and enter button, then issues one
// guess_valid strobe per accepted press together with the captured switch word.
module enter_input_conditioner
    import perp_puzz_pkg::*;
#(
    parameter int SW_WIDTH        = SW_WIDTH_DEF,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SW_WIDTH-1:0] sw_raw,
    input  logic                enter_raw,
    input  logic                enable,
    input  logic                clear_count,
    output logic [SW_WIDTH-1:0] sw_clean,
    output logic                enter_level,
    output logic [SW_WIDTH-1:0] guess,
    output logic                guess_valid,
    output logic [3:0]          guess_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SW_WIDTH-1:0] sw_s;
    logic                enter_s;

    sync2 #(.WIDTH(SW_WIDTH)) u_sync_sw (
        .clk   (clk),
        .reset (reset),
        .d     (sw_raw),
        .q     (sw_s)
    );

    sync2 #(.WIDTH(1)) u_sync_enter (
        .clk   (clk),
        .reset (reset),
        .d     (enter_raw),
        .q     (enter_s)
    );

    // Switch debounce: the whole vector must hold still before sw_clean follows it.
    logic [SW_WIDTH-1:0] sw_prev_q, sw_prev_d;
    logic [SW_WIDTH-1:0] sw_clean_q, sw_clean_d;
    logic [CNT_W-1:0]    sw_cnt_q, sw_cnt_d;

    always_comb begin
        sw_prev_d  = sw_s;
        sw_clean_d = sw_clean_q;
        sw_cnt_d   = sw_cnt_q;
        if (sw_s != sw_prev_q) begin
            sw_cnt_d = '0;
        end else if (sw_cnt_q != CNT_LAST) begin
            sw_cnt_d = sw_cnt_q + CNT_ONE;
            if (sw_cnt_q == CNT_LOAD) begin
                sw_clean_d = sw_s;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_prev_q  <= '0;
            sw_clean_q <= '0;
            sw_cnt_q   <= '0;
        end else begin
            sw_prev_q  <= sw_prev_d;
            sw_clean_q <= sw_clean_d;
            sw_cnt_q   <= sw_cnt_d;
        end
    end

    // Enter FSM: a press is accepted only on the debounced rising transition.
    enter_state_t        state_q, state_d;
    logic [CNT_W-1:0]    en_cnt_q, en_cnt_d;
    logic                enter_level_q, enter_level_d;
    logic                accept;
    logic [SW_WIDTH-1:0] guess_q, guess_d;
    logic                guess_valid_q, guess_valid_d;
    logic [3:0]          guess_count_q, guess_count_d;

    always_comb begin
        state_d       = state_q;
        en_cnt_d      = en_cnt_q;
        enter_level_d = enter_level_q;
        accept        = 1'b0;
        case (state_q)
            IDLE: begin
                if (enter_s) begin
                    state_d  = PRESS_WAIT;
                    en_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!enter_s) begin
                    state_d = IDLE;
                end else if (en_cnt_q == CNT_LAST) begin
                    state_d       = HELD;
                    enter_level_d = 1'b1;
                    accept        = enable;
                end else begin
                    en_cnt_d = en_cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!enter_s) begin
                    state_d  = RELEASE_WAIT;
                    en_cnt_d = '0;
                end
            end
            RELEASE_WAIT: begin
                if (enter_s) begin
                    state_d = HELD;
                end else if (en_cnt_q == CNT_LAST) begin
                    state_d       = IDLE;
                    enter_level_d = 1'b0;
                end else begin
                    en_cnt_d = en_cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // guess takes the pre-update sw_clean so a same-cycle switch load cannot leak in.
        guess_valid_d = accept;
        guess_d       = accept ? sw_clean_q : guess_q;
        guess_count_d = guess_count_q;
        if (clear_count) begin
            guess_count_d = 4'd0;
        end else if (accept && (guess_count_q != GUESS_CNT_MAX)) begin
            guess_count_d = guess_count_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            en_cnt_q      <= '0;
            enter_level_q <= 1'b0;
            guess_q       <= '0;
            guess_valid_q <= 1'b0;
            guess_count_q <= 4'd0;
        end else begin
            state_q       <= state_d;
            en_cnt_q      <= en_cnt_d;
            enter_level_q <= enter_level_d;
            guess_q       <= guess_d;
            guess_valid_q <= guess_valid_d;
            guess_count_q <= guess_count_d;
        end
    end

    assign sw_clean    = sw_clean_q;
    assign enter_level = enter_level_q;
    assign guess       = guess_q;
    assign guess_valid = guess_valid_q;
    assign guess_count = guess_count_q;

endmodule

// File: tb/tb_enter_input_conditioner.sv
// Self-checking bench for enter_input_conditioner with DEBOUNCE_CYCLES=4: scenario table,
// hand-written timing sequences and random stimulus against a run-length reference model.
module tb_enter_input_conditioner;

    localparam int W = 10;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw_raw;
    logic         enter_raw;
    logic         enable;
    logic         clear_count;
    logic [W-1:0] sw_clean;
    logic         enter_level;
    logic [W-1:0] guess;
    logic         guess_valid;
    logic [3:0]   guess_count;

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    always #5 clk = ~clk;

    enter_input_conditioner #(
        .SW_WIDTH        (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_raw      (sw_raw),
        .enter_raw   (enter_raw),
        .enable      (enable),
        .clear_count (clear_count),
        .sw_clean    (sw_clean),
        .enter_level (enter_level),
        .guess       (guess),
        .guess_valid (guess_valid),
        .guess_count (guess_count)
    );

    // Reference model: synchroniser as a two-deep delay line, debounce as run lengths.
    logic [W-1:0] m_sw1, m_sw2, m_prev, m_clean, m_guess;
    logic         m_en1, m_en2, m_level, m_valid;
    int           m_sw_run, m_en_run, m_count;

    task automatic model_reset();
        m_sw1 = '0; m_sw2 = '0; m_prev = '0; m_clean = '0; m_guess = '0;
        m_en1 = 1'b0; m_en2 = 1'b0; m_level = 1'b0; m_valid = 1'b0;
        m_sw_run = 1; m_en_run = 0; m_count = 0;
    endtask

    task automatic model_edge();
        logic [W-1:0] s;
        logic [W-1:0] old_clean;
        logic         e;
        s = m_sw2;
        e = m_en2;
        old_clean = m_clean;
        // sw_clean follows a value seen on D consecutive synchronised samples
        if (s == m_prev) begin
            if (m_sw_run < D) m_sw_run++;
        end else begin
            m_sw_run = 1;
        end
        m_prev = s;
        if (m_sw_run >= D) m_clean = s;
        // level flips after D+1 consecutive samples opposite to it
        m_valid = 1'b0;
        if (e != m_level) m_en_run++;
        else m_en_run = 0;
        if (m_en_run == D + 1) begin
            m_level = e;
            m_en_run = 0;
            if (e && enable) begin
                m_valid = 1'b1;
                m_guess = old_clean;
                if (m_count < 15) m_count++;
            end
        end
        if (clear_count) m_count = 0;
        m_sw2 = m_sw1; m_sw1 = sw_raw;
        m_en2 = m_en1; m_en1 = enter_raw;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_edge();
        @(negedge clk);
        chk("m_sw_clean", 32'(sw_clean), 32'(m_clean));
        chk("m_enter_level", 32'(enter_level), 32'(m_level));
        chk("m_guess", 32'(guess), 32'(m_guess));
        chk("m_guess_valid", 32'(guess_valid), 32'(m_valid));
        chk("m_guess_count", 32'(guess_count), 32'(m_count));
        if (guess_valid) strobes++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Steps up to n cycles and returns the 1-based edge of the first strobe (-1 if none).
    task automatic find_strobe(input int n, output int first);
        first = -1;
        for (int i = 1; i <= n; i++) begin
            step();
            if (guess_valid && first < 0) first = i;
        end
    endtask

    typedef struct {
        logic [W-1:0] sw;
        int           press;
        logic         en;
        int           exp_strobes;
        logic [W-1:0] exp_guess;
        int           exp_count;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int first;
        int en_hold;
        int sw_hold;
        int rst_hold;

        vecs[0] = '{sw: 10'h2A5, press: 20, en: 1'b1, exp_strobes: 1, exp_guess: 10'h2A5, exp_count: 1};
        vecs[1] = '{sw: 10'h155, press: 3,  en: 1'b1, exp_strobes: 0, exp_guess: 10'h2A5, exp_count: 1};
        vecs[2] = '{sw: 10'h0F0, press: 20, en: 1'b0, exp_strobes: 0, exp_guess: 10'h2A5, exp_count: 1};
        vecs[3] = '{sw: 10'h0F0, press: 20, en: 1'b1, exp_strobes: 1, exp_guess: 10'h0F0, exp_count: 2};
        vecs[4] = '{sw: 10'h3FF, press: 5,  en: 1'b1, exp_strobes: 1, exp_guess: 10'h3FF, exp_count: 3};
        vecs[5] = '{sw: 10'h001, press: 4,  en: 1'b1, exp_strobes: 0, exp_guess: 10'h3FF, exp_count: 3};

        // Reset held with raw inputs toggling: outputs stay cleared.
        reset = 1'b0; sw_raw = '0; enter_raw = 1'b0; enable = 1'b1; clear_count = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            enter_raw = ~enter_raw;
            sw_raw = W'($urandom);
            step();
            chk("rst_sw_clean", 32'(sw_clean), 32'd0);
            chk("rst_enter_level", 32'(enter_level), 32'd0);
            chk("rst_guess", 32'(guess), 32'd0);
            chk("rst_guess_valid", 32'(guess_valid), 32'd0);
            chk("rst_guess_count", 32'(guess_count), 32'd0);
        end

        // Release with the button already held: one strobe, 7 edges later.
        sw_raw = '0; enter_raw = 1'b1; reset = 1'b1; strobes = 0;
        find_strobe(14, first);
        chk("held_at_reset_latency", 32'(first), 32'd7);
        chk("held_at_reset_strobes", 32'(strobes), 32'd1);
        enter_raw = 1'b0;
        steps(12);

        clear_count = 1'b1;
        step();
        clear_count = 1'b0;
        chk("clear_count", 32'(guess_count), 32'd0);

        // Scenario table
        for (int v = 0; v < 6; v++) begin
            sw_raw = vecs[v].sw;
            enable = vecs[v].en;
            steps(10);
            strobes = 0;
            enter_raw = 1'b1;
            steps(vecs[v].press);
            enter_raw = 1'b0;
            steps(12);
            chk($sformatf("vec%0d_strobes", v), 32'(strobes), 32'(vecs[v].exp_strobes));
            chk($sformatf("vec%0d_guess", v), 32'(guess), 32'(vecs[v].exp_guess));
            chk($sformatf("vec%0d_count", v), 32'(guess_count), 32'(vecs[v].exp_count));
            $display("vec%0d sw=%h press=%0d en=%0b strobes=%0d guess=%h count=%0d",
                     v, vecs[v].sw, vecs[v].press, vecs[v].en, strobes, guess, guess_count);
        end
        enable = 1'b1;

        // Bounce 1,0,1,0 then stable high: strobe timed from the last rise.
        strobes = 0;
        enter_raw = 1'b1; step();
        enter_raw = 1'b0; step();
        enter_raw = 1'b1; step();
        enter_raw = 1'b0; step();
        enter_raw = 1'b1;
        find_strobe(14, first);
        chk("bounce_latency", 32'(first), 32'd7);
        chk("bounce_strobes", 32'(strobes), 32'd1);
        enter_raw = 1'b0;
        steps(12);

        // Saturation after 17 clean presses.
        clear_count = 1'b1; step(); clear_count = 1'b0;
        strobes = 0;
        for (int p = 0; p < 17; p++) begin
            enter_raw = 1'b1; steps(8);
            enter_raw = 1'b0; steps(8);
        end
        chk("sat_count", 32'(guess_count), 32'd15);
        chk("sat_strobes", 32'(strobes), 32'd17);

        // clear_count on the acceptance edge wins over the increment.
        enter_raw = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            if (i == 7) clear_count = 1'b1;
            step();
        end
        clear_count = 1'b0;
        chk("clr_vs_inc_strobe", 32'(guess_valid), 32'd1);
        chk("clr_vs_inc_count", 32'(guess_count), 32'd0);
        enter_raw = 1'b0;
        steps(12);

        // Switch glitch of 2 cycles is filtered; a stable change lands after 6 edges.
        sw_raw = 10'h100; steps(10);
        chk("sw_settle", 32'(sw_clean), 32'h100);
        sw_raw = 10'h108; steps(2);
        sw_raw = 10'h100;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("sw_glitch_hold", 32'(sw_clean), 32'h100);
        end
        sw_raw = 10'h0C3;
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (sw_clean == 10'h0C3 && first < 0) first = i;
        end
        chk("sw_latency", 32'(first), 32'd6);
        $display("switch change latency=%0d edges", first);

        // Random stimulus, including occasional mid-debounce resets.
        en_hold = 1; sw_hold = 1;
        for (int c = 0; c < 4000; c++) begin
            if (--en_hold == 0) begin
                enter_raw = ~enter_raw;
                en_hold = $urandom_range(1, 9);
            end
            if (--sw_hold == 0) begin
                sw_raw = W'($urandom);
                sw_hold = $urandom_range(1, 10);
            end
            enable = ($urandom_range(0, 5) != 0);
            clear_count = ($urandom_range(0, 60) == 0);
            if (reset && $urandom_range(0, 400) == 0) begin
                reset = 1'b0;
                model_reset();
                rst_hold = $urandom_range(1, 3);
            end else if (!reset && --rst_hold == 0) begin
                reset = 1'b1;
            end
            step();
        end
        reset = 1'b1;
        clear_count = 1'b0;
        steps(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
